// File: rtl/lane_move_ctrl_if.sv
// rtl/lane_move_ctrl_if.sv - lane switch / renderer handshake bundle for lane_move_ctrl
interface lane_move_ctrl_if #(
  parameter int NUM_LANES = 3
);
  localparam int LW = $clog2(NUM_LANES);

  logic          switch_left;
  logic          switch_right;
  logic          upd_ready;
  logic          upd_valid;
  logic [LW-1:0] lane;
  logic [7:0]    ox_loc;
  logic [6:0]    oy_loc;
  logic [7:0]    erase_x;
  logic [6:0]    erase_y;
  logic          blocked;

  // Controller side: takes switches and ready, publishes the erase/draw pair.
  modport master (
    input  switch_left, switch_right, upd_ready,
    output upd_valid, lane, ox_loc, oy_loc, erase_x, erase_y, blocked
  );

  // Renderer / switch side.
  modport slave (
    output switch_left, switch_right, upd_ready,
    input  upd_valid, lane, ox_loc, oy_loc, erase_x, erase_y, blocked
  );
endinterface

// File: rtl/lane_move_ctrl.sv
// rtl/lane_move_ctrl.sv - one-step-per-press lane controller (optional LANE_WRAP_EN: wrap at edges)
module lane_move_ctrl #(
  parameter int NUM_LANES  = 3,
  parameter int LANE0_X    = 30,
  parameter int LANE_PITCH = 40,
  parameter int CAR_Y      = 85,
  parameter int START_LANE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  lane_move_ctrl_if.master bus
);
  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_LANES - 1);
  localparam logic [LW-1:0] START_IDX  = LW'(START_LANE);
  localparam logic [7:0]    START_X    = 8'(LANE0_X + START_LANE * LANE_PITCH);
  localparam logic [6:0]    CAR_Y_POS  = 7'(CAR_Y);

  if (NUM_LANES < 2 || NUM_LANES > 8) begin : g_bad_lanes
    $error("lane_move_ctrl: NUM_LANES must be 2..8");
  end
  if (LANE0_X + (NUM_LANES - 1) * LANE_PITCH > 159) begin : g_bad_span
    $error("lane_move_ctrl: rightmost lane x exceeds 159");
  end
  if (START_LANE < 0 || START_LANE >= NUM_LANES) begin : g_bad_start
    $error("lane_move_ctrl: START_LANE out of range");
  end

  typedef enum logic [1:0] {IDLE, UPDATE, WAIT_REL} state_t;

  state_t        state;
  logic [LW-1:0] lane_q;
  logic [7:0]    ox_q;
  logic [7:0]    erase_x_q;
  logic          valid_q;
  logic          blocked_q;
  logic [LW-1:0] target;
  logic          at_edge;
  logic          refused;

  function automatic logic [7:0] lane_x(input logic [LW-1:0] l);
    return 8'(LANE0_X + int'(l) * LANE_PITCH);
  endfunction

  // Neighbouring lane in the requested direction, and whether that step crosses an edge.
  always_comb begin
    target  = lane_q;
    at_edge = 1'b0;
    if (bus.switch_left) begin
      if (lane_q == '0) begin
        at_edge = 1'b1;
        target  = LAST_LANE;
      end else begin
        target = lane_q - LW'(1);
      end
    end else begin
      if (lane_q == LAST_LANE) begin
        at_edge = 1'b1;
        target  = '0;
      end else begin
        target = lane_q + LW'(1);
      end
    end
`ifdef LANE_WRAP_EN
    refused = 1'b0;
`else
    refused = at_edge;
`endif
  end

  // Step FSM: one lane step per press, held until the renderer takes the pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lane_q    <= START_IDX;
      ox_q      <= START_X;
      erase_x_q <= START_X;
      valid_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      blocked_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.switch_left && bus.switch_right) begin
            state <= WAIT_REL;
          end else if (bus.switch_left || bus.switch_right) begin
            if (refused) begin
              blocked_q <= 1'b1;
              state     <= WAIT_REL;
            end else begin
              lane_q    <= target;
              erase_x_q <= ox_q;
              ox_q      <= lane_x(target);
              valid_q   <= 1'b1;
              state     <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (bus.upd_ready) begin
            valid_q <= 1'b0;
            state   <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!bus.switch_left && !bus.switch_right) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.upd_valid = valid_q;
  assign bus.lane      = lane_q;
  assign bus.ox_loc    = ox_q;
  assign bus.oy_loc    = CAR_Y_POS;
  assign bus.erase_x   = erase_x_q;
  assign bus.erase_y   = CAR_Y_POS;
  assign bus.blocked   = blocked_q;
endmodule

// File: doc/lane_move_ctrl.md
# lane_move_ctrl

Parametrised player-car lane controller for the coin-collector game. It converts the left/right lane switches into one lane step per press, across a configurable number of evenly spaced lanes. For each step it publishes an erase position (old lane) and a draw position (new lane) to the VGA renderer. The renderer acknowledges each step through a valid/ready handshake. This block replaces the fixed three-lane controller.

## Interface
- NUM_LANES, 3, number of lanes, 2..8
- LANE0_X, 30, x pixel of lane 0 (8-bit)
- LANE_PITCH, 40, x distance between adjacent lanes
- CAR_Y, 85, fixed car y pixel (7-bit)
- START_LANE, 1, lane index loaded on reset
- LW, $clog2(NUM_LANES), lane index width (derived localparam)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- switch_left  in  1  level, request move toward lane 0
- switch_right  in  1  level, request move toward lane NUM_LANES-1
- upd_ready  in  1  renderer accepts the current erase/draw pair
- upd_valid  out  1  erase/draw pair pending
- lane  out  LW  current lane index
- ox_loc  out  8  draw x = LANE0_X + lane*LANE_PITCH
- oy_loc  out  7  draw y = CAR_Y
- erase_x  out  8  x of the previous lane position
- erase_y  out  7  y of the previous position = CAR_Y
- blocked  out  1  one-cycle pulse: move refused at a boundary

## Operation
- Elaboration checks:
  - LANE0_X + (NUM_LANES-1)*LANE_PITCH ≤ 159.
  - START_LANE < NUM_LANES.
  - Any violation is a $error.
- Position arithmetic:
  - x is computed at 8 bits from the lane index.
  - Outputs are registered, never combinational from the inputs.
- State machine:
  - IDLE, UPDATE, WAIT_REL.
  - Reset state is IDLE.
- IDLE, exactly one switch high:
  - Compute the target lane.
  - Legal target: lane <= target, erase_x <= old x, ox_loc <= new x, upd_valid <= 1, go to UPDATE.
  - Boundary (left at lane 0 or right at the last lane): no move, blocked <= 1 for one cycle, go to WAIT_REL.
- IDLE, both switches high: ignored, no blocked pulse, go to WAIT_REL.
- IDLE, neither switch high: stay in IDLE.
- UPDATE:
  - Hold upd_valid, lane, and all positions stable until upd_ready=1 at a rising edge.
  - After the handshake, upd_valid <= 0 and go to WAIT_REL.
  - Switch changes during UPDATE are ignored; they are not queued.
- WAIT_REL: go to IDLE on the first edge where both switches are low. This enforces one step per press.
- Reset values:
  - state IDLE, lane START_LANE.
  - ox_loc and erase_x = LANE0_X + START_LANE*LANE_PITCH.
  - oy_loc and erase_y = CAR_Y.
  - upd_valid 0, blocked 0.

## Timing
- Switch sampled high in IDLE at edge N: new lane, positions, and upd_valid=1 are visible after edge N.
- Handshake rules:
  - A transfer occurs at the edge where upd_valid=1 and upd_ready=1.
  - upd_valid falls after that same edge.
  - Minimum step period is 3 cycles: IDLE → UPDATE → WAIT_REL → IDLE.
- upd_ready held high permanently: upd_valid is a one-cycle pulse.
- upd_ready while upd_valid=0: ignored.
- blocked is high for exactly the one cycle following the refusing edge.
- Reset mid-UPDATE:
  - upd_valid drops asynchronously.
  - lane and positions return to their reset values.
  - The pending pair is discarded.
- Switches must be synchronised upstream; this block does not debounce.

## Configuration
- Macro LANE_WRAP_EN.
- Defined:
  - A right move at lane NUM_LANES-1 goes to lane 0.
  - A left move at lane 0 goes to lane NUM_LANES-1.
  - Both are normal UPDATE steps: erase old x, draw new x.
  - blocked is tied to 0.
- Undefined: boundary moves are refused as described in Operation.

## Test plan
- Reset, defaults: lane=1, ox_loc=70, oy_loc=85, erase_x=70, upd_valid=0.
- Right held 10 cycles, upd_ready=1 → one step only: lane=2, erase_x=70, ox_loc=110, upd_valid high for one cycle. Release, press again → blocked pulse, lane stays 2. With LANE_WRAP_EN → lane=0, erase_x=110, ox_loc=30.
- upd_ready=0 for 5 cycles after a left press from lane 1:
  - upd_valid and positions (erase_x=70, ox_loc=30) held steady.
  - A right press during the wait has no effect.
  - Transfer completes on the upd_ready edge.
- Both switches high in IDLE → no move, no valid, no blocked. Release both → IDLE.
- reset_n low mid-UPDATE → upd_valid=0 immediately, lane=1, ox_loc=70.
- NUM_LANES=5, LANE0_X=10, LANE_PITCH=35: four right presses → ox_loc sequence 80, 115, 150, then blocked at lane 4.
